fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage for the pipelined core. It owns the program counter, issues one instruction-memory request at a time over a valid/ready request channel with a valid-only response, and loads the returned instruction into the IF/ID pipeline register consumed by decode. Decode stall and execute-stage redirect (taken branch or jump) are handled here. A one-entry response buffer absorbs responses that arrive while decode is stalled.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  request address (current PC), word-aligned
- imem_rsp_valid  in  1  response valid, single-cycle pulse, at earliest the cycle after acceptance
- imem_rsp_data  in  32  instruction word
- stall_d  in  1  decode cannot accept a new IF/ID entry
- redirect_valid  in  1  redirect request from execute
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0
- valid_d  out  1  IF/ID entry valid
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID instruction address
- pc_plus4_d  out  32  pc_d + 4, mod 2^32

## Operation
- State: pc, pc_inflight, buf_instr, buf_pc, FSM {REQ, WAIT, BUF, DROP}.
- IF/ID load enable: ld = !stall_d || !valid_d.
- REQ:
  - imem_req_valid = !redirect_valid; imem_addr = pc.
  - On redirect: pc <= redirect_pc, stay REQ.
  - Else on accept: pc_inflight <= pc, pc <= pc + 4, go WAIT.
- WAIT:
  - Redirect without response: pc <= redirect_pc, go DROP.
  - Redirect with response in the same cycle: discard response, pc <= redirect_pc, go REQ.
  - Response with ld: load IF/ID with {imem_rsp_data, pc_inflight, pc_inflight + 4}, go REQ.
  - Response without ld: buf <= {data, pc_inflight}, go BUF.
- BUF:
  - Redirect: discard buffer, pc <= redirect_pc, go REQ.
  - Else when ld: load IF/ID from buffer, go REQ.
- DROP:
  - Wait for the stale response; discard it and go REQ.
  - Redirect in DROP: pc <= redirect_pc, stay DROP.
  - If a redirect and the response coincide: take the new pc, go REQ.
- imem_req_valid = 0 in WAIT, BUF and DROP. Exactly one request is outstanding at most.
- IF/ID update priority:
  - redirect_valid clears valid_d.
  - Otherwise a load sets valid_d = 1 with the new entry.
  - Otherwise !stall_d clears valid_d (entry consumed).
  - Otherwise all IF/ID fields hold.
- instr_d, pc_d and pc_plus4_d hold their last value when valid_d = 0.
- imem_rsp_valid outside WAIT and DROP is a protocol violation; it is ignored.
- PC arithmetic is 32-bit unsigned with wrap: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values (asynchronous, effective immediately on rst):
  - pc = RESET_PC, state = REQ.
  - valid_d = 0; instr_d, pc_d, pc_plus4_d, buffer, pc_inflight = 0.
  - imem_req_valid = 0 while rst is high.
- First request is issued in the first cycle after rst deasserts.
- Throughput: best case one instruction per 2 cycles (REQ accept, response next cycle).
- Latency: valid_d rises on the edge that samples imem_rsp_valid in WAIT (if ld), or on the first ld edge in BUF.
- Redirect timing:
  - A redirect sampled on edge N clears valid_d at edge N.
  - The first request to the target is issued in the cycle after N, or after the stale response when in DROP.
- Reset mid-transaction abandons any outstanding response. The memory is reset concurrently, so no stale response arrives.

## Test plan
- Reset RESET_PC=0x100, ready=1, response 1 cycle after accept, stall_d=0 -> addresses 0x100, 0x104, 0x108; valid_d pulses every 2 cycles with matching pc_d/instr_d and pc_plus4_d = pc_d + 4.
- stall_d=1 for 4 cycles with valid_d=1 while the next response arrives -> FSM enters BUF, IF/ID holds; on release the IF/ID sees the buffered word next edge with no loss or duplication.
- Redirect to 0x200 while in WAIT, stale response arrives 3 cycles later -> stale word never reaches IF/ID, valid_d=0, next imem_addr = 0x200.
- Redirect and response in the same cycle; also redirect in REQ with ready=1 -> no request issued to the old pc, next request is at the target, valid_d=0.
- Redirect to 0xFFFF_FFFF -> imem_addr = 0xFFFF_FFFC; after fetch pc_plus4_d = 0 and the next address is 0x0.
- Assert rst while in WAIT with valid_d=1 -> all outputs go to reset values immediately; the first request after release is to RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// The request channel uses a valid/ready handshake; the response is valid-only.
interface fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps at most one memory request in flight,
// and fills the IF/ID register, with a one-entry buffer for responses that arrive during a decode stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     imem,
  input  logic        i_stall_d,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid_d,
  output logic [31:0] o_instr_d,
  output logic [31:0] o_pc_d,
  output logic [31:0] o_pc_plus4_d
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_BUF, S_DROP} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_inflight;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;
  logic        r_valid_d;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;

  logic        w_ld;
  logic        w_accept;
  logic        w_load;
  logic [31:0] w_load_instr;
  logic [31:0] w_load_pc;
  logic [31:0] w_target;
  logic        w_unused_lsb;

  assign w_target     = {i_redirect_pc[31:2], 2'b00};
  assign w_unused_lsb = ^i_redirect_pc[1:0];

  // Request is suppressed during reset and whenever a redirect is pending, so the old PC is never fetched.
  assign imem.req_valid = !rst && (r_state == S_REQ) && !i_redirect_valid;
  assign imem.addr      = r_pc;
  assign w_accept       = imem.req_valid && imem.req_ready;

  assign w_ld   = !i_stall_d || !r_valid_d;
  assign w_load = !i_redirect_valid && w_ld &&
                  (((r_state == S_WAIT) && imem.rsp_valid) || (r_state == S_BUF));
  assign w_load_instr = (r_state == S_BUF) ? r_buf_instr : imem.rsp_data;
  assign w_load_pc    = (r_state == S_BUF) ? r_buf_pc    : r_pc_inflight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_pc_inflight <= '0;
      r_buf_instr   <= '0;
      r_buf_pc      <= '0;
      r_valid_d     <= 1'b0;
      r_instr_d     <= '0;
      r_pc_d        <= '0;
      r_pc_plus4_d  <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (i_redirect_valid) begin
            r_pc <= w_target;
          end else if (w_accept) begin
            r_pc_inflight <= r_pc;
            r_pc          <= r_pc + 32'd4;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_redirect_valid) begin
            r_pc    <= w_target;
            r_state <= imem.rsp_valid ? S_REQ : S_DROP;
          end else if (imem.rsp_valid) begin
            if (w_ld) begin
              r_state <= S_REQ;
            end else begin
              r_buf_instr <= imem.rsp_data;
              r_buf_pc    <= r_pc_inflight;
              r_state     <= S_BUF;
            end
          end
        end
        S_BUF: begin
          if (i_redirect_valid) begin
            r_pc    <= w_target;
            r_state <= S_REQ;
          end else if (w_ld) begin
            r_state <= S_REQ;
          end
        end
        S_DROP: begin
          // The stale response is swallowed here; a redirect only retargets the next fetch.
          if (i_redirect_valid) r_pc <= w_target;
          if (imem.rsp_valid)   r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase

      // IF/ID register: flush beats load, load beats consume, otherwise hold.
      if (i_redirect_valid) begin
        r_valid_d <= 1'b0;
      end else if (w_load) begin
        r_valid_d    <= 1'b1;
        r_instr_d    <= w_load_instr;
        r_pc_d       <= w_load_pc;
        r_pc_plus4_d <= w_load_pc + 32'd4;
      end else if (!i_stall_d) begin
        r_valid_d <= 1'b0;
      end
    end
  end

  assign o_valid_d    = r_valid_d;
  assign o_instr_d    = r_instr_d;
  assign o_pc_d       = r_pc_d;
  assign o_pc_plus4_d = r_pc_plus4_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run scored against an in-order PC stream model.
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redir;
  logic [31:0] rpc;
  logic        valid_d;
  logic [31:0] instr_d, pc_d, pc_p4;

  fetch_if imem_bus();

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem             (imem_bus.master),
    .i_stall_d        (stall),
    .i_redirect_valid (redir),
    .i_redirect_pc    (rpc),
    .o_valid_d        (valid_d),
    .o_instr_d        (instr_d),
    .o_pc_d           (pc_d),
    .o_pc_plus4_d     (pc_p4)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model state
  bit          pend;
  int          cnt;
  int          lat;
  logic [31:0] pend_addr;

  // Values sampled before the active edge of the last cycle
  logic        s_req, s_vd, s_busy;
  logic [31:0] s_addr, s_pc, s_ins, s_p4;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_1357;
  endfunction

  task automatic cyc(input logic st, input logic rd, input logic [31:0] tgt, input logic rdy);
    stall = st; redir = rd; rpc = tgt; imem_bus.req_ready = rdy;
    if (pend && cnt == 0) begin
      imem_bus.rsp_valid = 1'b1;
      imem_bus.rsp_data  = word_at(pend_addr);
      pend = 1'b0;
    end else begin
      imem_bus.rsp_valid = 1'b0;
      imem_bus.rsp_data  = $urandom;
      if (pend) cnt--;
    end
    #1;
    s_req  = imem_bus.req_valid; s_addr = imem_bus.addr;
    s_vd   = valid_d; s_pc = pc_d; s_ins = instr_d; s_p4 = pc_p4;
    s_busy = pend || imem_bus.rsp_valid;
    @(posedge clk);
    if (s_req && rdy) begin
      pend = 1'b1; pend_addr = s_addr; cnt = lat - 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = '0;
    imem_bus.req_ready = 1'b0; imem_bus.rsp_valid = 1'b0; imem_bus.rsp_data = '0;
    pend = 1'b0; cnt = 0; lat = 1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = '0;
    imem_bus.req_ready = 1'b1; imem_bus.rsp_valid = 1'b0; imem_bus.rsp_data = '0;
    pend = 1'b0; lat = 1;
    @(negedge clk); #1;
    n_tests++; if (imem_bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_bus.req_valid); end
    n_tests++; if (imem_bus.addr !== RPC) begin n_fail++; $display("FAIL reset_addr got=%h exp=%h", imem_bus.addr, RPC); end
    n_tests++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
    n_tests++; if ({instr_d, pc_d, pc_p4} !== 96'h0) begin n_fail++; $display("FAIL reset_ifid got=%h/%h/%h exp=0", instr_d, pc_d, pc_p4); end
    @(negedge clk);
  endtask

  task automatic test_sequential();
    logic [31:0] epc;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, '0, 1'b1);
      n_tests++; if (s_req !== (k % 2 == 0)) begin n_fail++; $display("FAIL seq_req k=%0d got=%b", k, s_req); end
      if (k % 2 == 0) begin
        n_tests++; if (s_addr !== RPC + 32'(2 * k)) begin n_fail++; $display("FAIL seq_addr k=%0d got=%h exp=%h", k, s_addr, RPC + 32'(2 * k)); end
      end
      n_tests++; if (s_vd !== (k >= 2 && k % 2 == 0)) begin n_fail++; $display("FAIL seq_valid k=%0d got=%b", k, s_vd); end
      if (k >= 2 && k % 2 == 0) begin
        epc = RPC + 32'(2 * (k - 2));
        n_tests++;
        if (s_pc !== epc || s_ins !== word_at(epc) || s_p4 !== epc + 32'd4) begin
          n_fail++; $display("FAIL seq_entry k=%0d got=%h/%h/%h exp=%h/%h/%h", k, s_pc, s_ins, s_p4, epc, word_at(epc), epc + 32'd4);
        end
      end
    end
  endtask

  task automatic test_stall_buffer();
    logic [9:0]  vd_t, req_t;
    logic [31:0] pcs [10];
    logic [31:0] adr [10];
    vd_t  = 10'b10_1111_1100;
    req_t = 10'b10_1000_0101;
    pcs = '{32'h0, 32'h0, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h104, 32'h0, 32'h108};
    adr = '{32'h100, 32'h0, 32'h104, 32'h0, 32'h0, 32'h0, 32'h0, 32'h108, 32'h0, 32'h10C};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc(k >= 2 && k <= 5, 1'b0, '0, 1'b1);
      n_tests++; if (s_vd !== vd_t[k]) begin n_fail++; $display("FAIL stall_valid k=%0d got=%b exp=%b", k, s_vd, vd_t[k]); end
      n_tests++; if (s_req !== req_t[k]) begin n_fail++; $display("FAIL stall_req k=%0d got=%b exp=%b", k, s_req, req_t[k]); end
      if (req_t[k]) begin
        n_tests++; if (s_addr !== adr[k]) begin n_fail++; $display("FAIL stall_addr k=%0d got=%h exp=%h", k, s_addr, adr[k]); end
      end
      if (vd_t[k]) begin
        n_tests++; if (s_pc !== pcs[k] || s_ins !== word_at(pcs[k])) begin
          n_fail++; $display("FAIL stall_entry k=%0d got=%h/%h exp=%h/%h", k, s_pc, s_ins, pcs[k], word_at(pcs[k]));
        end
      end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    lat = 4;
    cyc(1'b0, 1'b0, '0, 1'b1);
    n_tests++; if (s_req !== 1'b1 || s_addr !== RPC) begin n_fail++; $display("FAIL rw_first got=%b/%h", s_req, s_addr); end
    cyc(1'b0, 1'b1, 32'h200, 1'b1);
    for (int k = 2; k <= 4; k++) begin
      cyc(1'b0, 1'b0, '0, 1'b1);
      n_tests++; if (s_req !== 1'b0 || s_vd !== 1'b0) begin n_fail++; $display("FAIL rw_drop k=%0d got req=%b vd=%b exp 0/0", k, s_req, s_vd); end
    end
    lat = 1;
    cyc(1'b0, 1'b0, '0, 1'b1);
    n_tests++; if (s_req !== 1'b1 || s_addr !== 32'h200 || s_vd !== 1'b0) begin n_fail++; $display("FAIL rw_target got=%b/%h vd=%b exp 1/00000200 vd=0", s_req, s_addr, s_vd); end
    cyc(1'b0, 1'b0, '0, 1'b1);
    n_tests++; if (s_vd !== 1'b0) begin n_fail++; $display("FAIL rw_stale got vd=%b pc=%h exp vd=0", s_vd, s_pc); end
    cyc(1'b0, 1'b0, '0, 1'b1);
    n_tests++; if (s_vd !== 1'b1 || s_pc !== 32'h200 || s_ins !== word_at(32'h200) || s_p4 !== 32'h204) begin
      n_fail++; $display("FAIL rw_entry got=%b/%h/%h/%h exp=1/00000200/%h/00000204", s_vd, s_pc, s_ins, s_p4, word_at(32'h200));
    end
  endtask

  task automatic test_redirect_same();
    do_reset();
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, 32'h300, 1'b1);
    cyc(1'b0, 1'b1, 32'h400, 1'b1);
    n_tests++; if (s_req !== 1'b0 || s_vd !== 1'b0) begin n_fail++; $display("FAIL rs_req_in_req got req=%b vd=%b exp 0/0", s_req, s_vd); end
    cyc(1'b0, 1'b0, '0, 1'b1);
    n_tests++; if (s_req !== 1'b1 || s_addr !== 32'h400 || s_vd !== 1'b0) begin n_fail++; $display("FAIL rs_target got=%b/%h vd=%b exp 1/00000400 vd=0", s_req, s_addr, s_vd); end
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b1, 32'h503, 1'b1);
    n_tests++; if (s_vd !== 1'b1 || s_pc !== 32'h400 || s_req !== 1'b0) begin n_fail++; $display("FAIL rs_entry got vd=%b pc=%h req=%b exp 1/00000400/0", s_vd, s_pc, s_req); end
    cyc(1'b1, 1'b0, '0, 1'b1);
    n_tests++; if (s_vd !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h500) begin n_fail++; $display("FAIL rs_flush got vd=%b req=%b addr=%h exp 0/1/00000500", s_vd, s_req, s_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    n_tests++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL wrap_req0 got=%b exp=0", s_req); end
    cyc(1'b0, 1'b0, '0, 1'b1);
    n_tests++; if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr got=%b/%h exp 1/fffffffc", s_req, s_addr); end
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    n_tests++; if (s_vd !== 1'b1 || s_pc !== 32'hFFFF_FFFC || s_p4 !== 32'h0) begin n_fail++; $display("FAIL wrap_entry got=%b/%h/%h exp 1/fffffffc/00000000", s_vd, s_pc, s_p4); end
    n_tests++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next got=%b/%h exp 1/00000000", s_req, s_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1);
    n_tests++; if (valid_d !== 1'b1) begin n_fail++; $display("FAIL rm_pre got vd=%b exp=1", valid_d); end
    rst = 1'b1; pend = 1'b0; imem_bus.rsp_valid = 1'b0;
    #1;
    n_tests++; if (valid_d !== 1'b0 || {instr_d, pc_d, pc_p4} !== 96'h0 || imem_bus.req_valid !== 1'b0 || imem_bus.addr !== RPC) begin
      n_fail++; $display("FAIL rm_async got vd=%b ifid=%h/%h/%h req=%b addr=%h", valid_d, instr_d, pc_d, pc_p4, imem_bus.req_valid, imem_bus.addr);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, '0, 1'b1);
    n_tests++; if (s_req !== 1'b1 || s_addr !== RPC || s_vd !== 1'b0) begin n_fail++; $display("FAIL rm_first got=%b/%h vd=%b", s_req, s_addr, s_vd); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic        st, rd, rdy;
    logic [31:0] tgt;
    int          delivered = 0;
    do_reset();
    exp_pc = RPC;
    for (int k = 0; k < 1500; k++) begin
      st  = ($urandom % 10) < 4;
      rd  = ($urandom % 25) == 0;
      rdy = ($urandom % 10) < 7;
      tgt = $urandom;
      lat = 1 + int'($urandom % 3);
      cyc(st, rd, tgt, rdy);
      n_tests++; if (s_req && s_busy) begin n_fail++; $display("FAIL rnd_outstanding k=%0d req while busy addr=%h", k, s_addr); end
      if (rd) begin
        exp_pc = {tgt[31:2], 2'b00};
      end else if (s_vd && !st) begin
        n_tests++;
        if (s_pc !== exp_pc || s_ins !== word_at(exp_pc) || s_p4 !== exp_pc + 32'd4) begin
          n_fail++; $display("FAIL rnd_entry k=%0d got=%h/%h/%h exp=%h/%h/%h", k, s_pc, s_ins, s_p4, exp_pc, word_at(exp_pc), exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    n_tests++; if (delivered < 50) begin n_fail++; $display("FAIL rnd_progress got=%0d exp>=50", delivered); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_buffer();
    test_redirect_wait();
    test_redirect_same();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
